// File: rtl/core_cache_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// core_cache_ctrl_pkg
//   Shared definitions for the core-to-data-cache request controller:
//   FSM state encodings and the default address/data field widths.
//   Imported by core_cache_wbuf and core_cache_ctrl.
// -----------------------------------------------------------------------------
package core_cache_ctrl_pkg;

  // Address field widths of the cache port.
  localparam int CACHE_INDEX_AW  = 8;
  localparam int CACHE_TAG_WIDTH = 20;
  localparam int CACHE_OFFSET_AW = 4;

  // Byte lanes (one write-enable bit each) and datapath widths.
  localparam int RAM_NUM         = 4;
  localparam int DATA_WIDTH      = 32;
  localparam int RV32_ADDR_WIDTH = 32;

  // Request sequencer states. Each transaction goes through an address
  // phase (request held until addr_ack) and a data phase (until data_ack).
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_ADDR = 3'd3,
    S_WR_DATA = 3'd4
  } cache_state_e;

endpackage : core_cache_ctrl_pkg

// File: rtl/core_cache_wbuf.sv
// -----------------------------------------------------------------------------
// core_cache_wbuf
//   One-entry posted-store buffer. A store is taken whenever the CPU offers
//   one and the entry is empty (registered valid, so a store offered in the
//   cycle the entry drains is taken one cycle later). The controller clears
//   the entry once the cache reports the write done.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   wr_req_i        CPU store request
//   wr_addr_i       store address
//   wr_data_i       store data
//   wr_en_i         store byte enables
//   clear_i         drain complete, free the entry
//   accept_o        store is being taken this cycle
//   valid_o         entry holds a store
//   addr_o/data_o/be_o  buffered store payload
// -----------------------------------------------------------------------------
module core_cache_wbuf
  import core_cache_ctrl_pkg::*;
#(
  parameter int ADDR_W = RV32_ADDR_WIDTH,
  parameter int DATA_W = DATA_WIDTH,
  parameter int NUM_BE = RAM_NUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [NUM_BE-1:0] wr_en_i,
  input  logic              clear_i,
  output logic              accept_o,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic [NUM_BE-1:0] be_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [NUM_BE-1:0] be_q,    be_d;

  assign accept_o = wr_req_i & ~valid_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    // Clear and accept are exclusive: accept requires valid_q = 0, clear only
    // happens while the entry is being drained (valid_q = 1).
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (accept_o) begin
      valid_d = 1'b1;
      addr_d  = wr_addr_i;
      data_d  = wr_data_i;
      be_d    = wr_en_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the payload is a single entry, so resetting it is cheap and keeps
      // the cache-side outputs at a defined zero out of reset; a deeper buffer
      // would be a RAM and only its valid bits would be reset.
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order.
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;
  assign be_o    = be_q;

endmodule : core_cache_wbuf

// File: rtl/core_cache_ctrl.sv
// -----------------------------------------------------------------------------
// core_cache_ctrl
//   Owns the single data-cache request channel. Posts stores into a one-entry
//   buffer, drains that buffer ahead of any younger load, sequences each
//   transaction through the cache's addr_ack / data_ack handshake, returns
//   load data with a one-cycle valid pulse, and drives the pipeline stall.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   cpu_rd_req_i         load request, held with stable address until valid
//   cpu_rd_addr_i        load address
//   cpu_wr_req_i         store request, held until accepted
//   cpu_wr_addr_i/cpu_wr_data_i/cpu_wr_en_i  store address, data, byte enables
//   cpu_rd_data_o        load data, valid with cpu_rd_valid_o
//   cpu_rd_valid_o       one-cycle load-complete pulse
//   pipeline_stall_o     stall the core (combinational)
//   cache_req_o          request, held until cache_addr_ack_i
//   cache_op_o           0 = read, 1 = write
//   cache_index_o/cache_tag_o/cache_offset_o  address fields
//   cache_wr_en_o        byte enables, zero on reads
//   cache_wr_data_o      write data
//   cache_rd_data_i      read data, valid with cache_data_ack_i
//   cache_addr_ack_i     request accepted
//   cache_data_ack_i     transaction complete
// -----------------------------------------------------------------------------
module core_cache_ctrl
  import core_cache_ctrl_pkg::*;
#(
  parameter int ADDR_W   = RV32_ADDR_WIDTH,
  parameter int DATA_W   = DATA_WIDTH,
  parameter int INDEX_W  = CACHE_INDEX_AW,
  parameter int OFFSET_W = CACHE_OFFSET_AW,
  parameter int TAG_W    = CACHE_TAG_WIDTH,
  parameter int NUM_BE   = RAM_NUM
) (
  input  logic                clk,
  input  logic                rst,
  // CPU load/store side
  input  logic                cpu_rd_req_i,
  input  logic [ADDR_W-1:0]   cpu_rd_addr_i,
  input  logic                cpu_wr_req_i,
  input  logic [ADDR_W-1:0]   cpu_wr_addr_i,
  input  logic [DATA_W-1:0]   cpu_wr_data_i,
  input  logic [NUM_BE-1:0]   cpu_wr_en_i,
  output logic [DATA_W-1:0]   cpu_rd_data_o,
  output logic                cpu_rd_valid_o,
  output logic                pipeline_stall_o,
  // Cache side
  output logic                cache_req_o,
  output logic                cache_op_o,
  output logic [INDEX_W-1:0]  cache_index_o,
  output logic [TAG_W-1:0]    cache_tag_o,
  output logic [OFFSET_W-1:0] cache_offset_o,
  output logic [NUM_BE-1:0]   cache_wr_en_o,
  output logic [DATA_W-1:0]   cache_wr_data_o,
  input  logic [DATA_W-1:0]   cache_rd_data_i,
  input  logic                cache_addr_ack_i,
  input  logic                cache_data_ack_i
);

  // ---------------------------------------------------------------------------
  // Store buffer
  // ---------------------------------------------------------------------------
  logic              wb_accept;
  logic              wb_valid;
  logic              wb_clear;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [NUM_BE-1:0] wb_be;

  core_cache_wbuf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .NUM_BE (NUM_BE)
  ) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .wr_req_i  (cpu_wr_req_i),
    .wr_addr_i (cpu_wr_addr_i),
    .wr_data_i (cpu_wr_data_i),
    .wr_en_i   (cpu_wr_en_i),
    .clear_i   (wb_clear),
    .accept_o  (wb_accept),
    .valid_o   (wb_valid),
    .addr_o    (wb_addr),
    .data_o    (wb_data),
    .be_o      (wb_be)
  );

  // ---------------------------------------------------------------------------
  // State and request registers
  // ---------------------------------------------------------------------------
  cache_state_e      state_q,    state_d;
  logic              req_q,      req_d;
  logic              op_q,       op_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [NUM_BE-1:0] be_q,       be_d;
  logic [DATA_W-1:0] wdata_q,    wdata_d;
  logic [DATA_W-1:0] rd_data_q,  rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    op_d       = op_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    wb_clear   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A buffered store always goes first, so a younger load to the same
        // address sees the stored data from the cache; no forwarding needed.
        if (wb_valid) begin
          state_d = S_WR_ADDR;
          req_d   = 1'b1;
          op_d    = 1'b1;
          addr_d  = wb_addr;
          be_d    = wb_be;
          wdata_d = wb_data;
        end else if (cpu_rd_req_i && !rd_valid_q && !wb_accept) begin
          // rd_valid_q masks the held request in its completion cycle; a store
          // entering the buffer now must drain before this load issues.
          state_d = S_RD_ADDR;
          req_d   = 1'b1;
          op_d    = 1'b0;
          addr_d  = cpu_rd_addr_i;
          be_d    = '0;
          wdata_d = '0;
        end
      end

      S_RD_ADDR: begin
        if (cache_addr_ack_i) begin
          req_d = 1'b0;
          // Both acks in the same cycle complete the transaction at once.
          if (cache_data_ack_i) begin
            rd_data_d  = cache_rd_data_i;
            rd_valid_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            state_d = S_RD_DATA;
          end
        end
      end

      S_RD_DATA: begin
        if (cache_data_ack_i) begin
          rd_data_d  = cache_rd_data_i;
          rd_valid_d = 1'b1;
          state_d    = S_IDLE;
        end
      end

      S_WR_ADDR: begin
        if (cache_addr_ack_i) begin
          req_d = 1'b0;
          if (cache_data_ack_i) begin
            wb_clear = 1'b1;
            state_d  = S_IDLE;
          end else begin
            state_d = S_WR_DATA;
          end
        end
      end

      S_WR_DATA: begin
        if (cache_data_ack_i) begin
          wb_clear = 1'b1;
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      op_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cpu_rd_data_o   = rd_data_q;
  assign cpu_rd_valid_o  = rd_valid_q;

  assign cache_req_o     = req_q;
  assign cache_op_o      = op_q;
  assign cache_offset_o  = addr_q[OFFSET_W-1:0];
  assign cache_index_o   = addr_q[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign cache_tag_o     = addr_q[ADDR_W-1:OFFSET_W+INDEX_W];
  assign cache_wr_en_o   = be_q;
  assign cache_wr_data_o = wdata_q;

  // Stall while a load is outstanding, or while a store waits on a full buffer.
  assign pipeline_stall_o = (cpu_rd_req_i & ~rd_valid_q) | (cpu_wr_req_i & wb_valid);

endmodule : core_cache_ctrl

// File: tb/tb_core_cache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_core_cache_ctrl
//   Directed bench for core_cache_ctrl. Inputs change 1 ns after the rising
//   edge; outputs are sampled on the falling edge. Cycle numbers in comments
//   count from the cycle in which the request is first presented.
// -----------------------------------------------------------------------------
module tb_core_cache_ctrl;
  import core_cache_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rd_req_i;
  logic [31:0] cpu_rd_addr_i;
  logic        cpu_wr_req_i;
  logic [31:0] cpu_wr_addr_i;
  logic [31:0] cpu_wr_data_i;
  logic [3:0]  cpu_wr_en_i;
  logic [31:0] cpu_rd_data_o;
  logic        cpu_rd_valid_o;
  logic        pipeline_stall_o;
  logic        cache_req_o;
  logic        cache_op_o;
  logic [7:0]  cache_index_o;
  logic [19:0] cache_tag_o;
  logic [3:0]  cache_offset_o;
  logic [3:0]  cache_wr_en_o;
  logic [31:0] cache_wr_data_o;
  logic [31:0] cache_rd_data_i;
  logic        cache_addr_ack_i;
  logic        cache_data_ack_i;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  core_cache_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .cpu_rd_req_i     (cpu_rd_req_i),
    .cpu_rd_addr_i    (cpu_rd_addr_i),
    .cpu_wr_req_i     (cpu_wr_req_i),
    .cpu_wr_addr_i    (cpu_wr_addr_i),
    .cpu_wr_data_i    (cpu_wr_data_i),
    .cpu_wr_en_i      (cpu_wr_en_i),
    .cpu_rd_data_o    (cpu_rd_data_o),
    .cpu_rd_valid_o   (cpu_rd_valid_o),
    .pipeline_stall_o (pipeline_stall_o),
    .cache_req_o      (cache_req_o),
    .cache_op_o       (cache_op_o),
    .cache_index_o    (cache_index_o),
    .cache_tag_o      (cache_tag_o),
    .cache_offset_o   (cache_offset_o),
    .cache_wr_en_o    (cache_wr_en_o),
    .cache_wr_data_o  (cache_wr_data_o),
    .cache_rd_data_i  (cache_rd_data_i),
    .cache_addr_ack_i (cache_addr_ack_i),
    .cache_data_ack_i (cache_data_ack_i)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [7:0]  exp_index;
    logic [19:0] exp_tag;
    logic [3:0]  exp_offset;
  } load_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " cache_req"},    {31'd0, cache_req_o},     32'd0);
    check({tag, " cache_op"},     {31'd0, cache_op_o},      32'd0);
    check({tag, " cache_index"},  {24'd0, cache_index_o},   32'd0);
    check({tag, " cache_tag"},    {12'd0, cache_tag_o},     32'd0);
    check({tag, " cache_offset"}, {28'd0, cache_offset_o},  32'd0);
    check({tag, " cache_wr_en"},  {28'd0, cache_wr_en_o},   32'd0);
    check({tag, " cache_wr_data"}, cache_wr_data_o,         32'd0);
    check({tag, " rd_data"},       cpu_rd_data_o,           32'd0);
    check({tag, " rd_valid"},     {31'd0, cpu_rd_valid_o},  32'd0);
    check({tag, " state"},        {29'd0, dut.state_q},     {29'd0, S_IDLE});
    check({tag, " wb_valid"},     {31'd0, dut.wb_valid},    32'd0);
  endtask

  // Load with acks in the earliest possible cycles: valid at cycle 3.
  task automatic do_load(input load_vec_t v, input int idx);
    string t;
    t = $sformatf("load[%0d]", idx);
    cpu_rd_req_i  = 1'b1;
    cpu_rd_addr_i = v.addr;
    sample();                                     // cycle 0
    check({t, " c0 stall"}, {31'd0, pipeline_stall_o}, 32'd1);
    check({t, " c0 req"},   {31'd0, cache_req_o},      32'd0);
    step();
    sample();                                     // cycle 1
    check({t, " c1 req"},    {31'd0, cache_req_o},    32'd1);
    check({t, " c1 op"},     {31'd0, cache_op_o},     32'd0);
    check({t, " c1 index"},  {24'd0, cache_index_o},  {24'd0, v.exp_index});
    check({t, " c1 tag"},    {12'd0, cache_tag_o},    {12'd0, v.exp_tag});
    check({t, " c1 offset"}, {28'd0, cache_offset_o}, {28'd0, v.exp_offset});
    check({t, " c1 wr_en"},  {28'd0, cache_wr_en_o},  32'd0);
    check({t, " c1 stall"},  {31'd0, pipeline_stall_o}, 32'd1);
    cache_addr_ack_i = 1'b1;
    step();
    cache_addr_ack_i = 1'b0;
    sample();                                     // cycle 2
    check({t, " c2 req"},   {31'd0, cache_req_o},      32'd0);
    check({t, " c2 valid"}, {31'd0, cpu_rd_valid_o},   32'd0);
    check({t, " c2 stall"}, {31'd0, pipeline_stall_o}, 32'd1);
    cache_data_ack_i = 1'b1;
    cache_rd_data_i  = v.rdata;
    step();
    cache_data_ack_i = 1'b0;
    cache_rd_data_i  = 32'h0;
    sample();                                     // cycle 3
    check({t, " c3 valid"}, {31'd0, cpu_rd_valid_o},   32'd1);
    check({t, " c3 data"},  cpu_rd_data_o,             v.rdata);
    check({t, " c3 stall"}, {31'd0, pipeline_stall_o}, 32'd0);
    cpu_rd_req_i = 1'b0;
    step();
    sample();                                     // cycle 4
    check({t, " c4 valid"}, {31'd0, cpu_rd_valid_o}, 32'd0);
    check({t, " c4 req"},   {31'd0, cache_req_o},    32'd0);
    step();
  endtask

  load_vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{32'h0000_1234, 32'hDEAD_BEEF, 8'h23, 20'h00001, 4'h4};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0F0F_0F0F, 8'hFF, 20'hFFFFF, 4'hF};
    vecs[2] = '{32'h8000_0010, 32'h8000_0001, 8'h01, 20'h80000, 4'h0};
    vecs[3] = '{32'h1234_5678, 32'hA5A5_5A5A, 8'h67, 20'h12345, 4'h8};
    vecs[4] = '{32'h0000_0000, 32'hFFFF_FFFF, 8'h00, 20'h00000, 4'h0};

    rst              = 1'b1;
    cpu_rd_req_i     = 1'b0;
    cpu_rd_addr_i    = '0;
    cpu_wr_req_i     = 1'b0;
    cpu_wr_addr_i    = '0;
    cpu_wr_data_i    = '0;
    cpu_wr_en_i      = '0;
    cache_rd_data_i  = '0;
    cache_addr_ack_i = 1'b0;
    cache_data_ack_i = 1'b0;

    // ---- Reset state; stall is combinational even during reset ----
    step();
    step();
    sample();
    check_all_zero("reset");
    check("reset stall idle", {31'd0, pipeline_stall_o}, 32'd0);
    cpu_rd_req_i = 1'b1;
    #1;
    check("reset stall rd_req", {31'd0, pipeline_stall_o}, 32'd1);
    cpu_rd_req_i = 1'b0;
    step();
    rst = 1'b0;
    step();

    // ---- Table-driven loads: address split and minimum latency ----
    for (int i = 0; i < 5; i++) do_load(vecs[i], i);

    // ---- Single store 0x2008: no stall, request at cycle 2, free at cycle 4 ----
    cpu_wr_req_i  = 1'b1;
    cpu_wr_addr_i = 32'h0000_2008;
    cpu_wr_data_i = 32'h55AA_55AA;
    cpu_wr_en_i   = 4'hF;
    sample();                                     // cycle 0
    check("st c0 stall", {31'd0, pipeline_stall_o}, 32'd0);
    step();
    cpu_wr_req_i = 1'b0;
    sample();                                     // cycle 1
    check("st c1 wb_valid", {31'd0, dut.wb_valid}, 32'd1);
    check("st c1 req",      {31'd0, cache_req_o},  32'd0);
    step();
    sample();                                     // cycle 2
    check("st c2 req",    {31'd0, cache_req_o},    32'd1);
    check("st c2 op",     {31'd0, cache_op_o},     32'd1);
    check("st c2 wr_en",  {28'd0, cache_wr_en_o},  32'hF);
    check("st c2 data",   cache_wr_data_o,         32'h55AA_55AA);
    check("st c2 index",  {24'd0, cache_index_o},  32'h00);
    check("st c2 tag",    {12'd0, cache_tag_o},    32'h00002);
    check("st c2 offset", {28'd0, cache_offset_o}, 32'h8);
    cache_addr_ack_i = 1'b1;
    step();
    cache_addr_ack_i = 1'b0;
    sample();                                     // cycle 3
    check("st c3 req",      {31'd0, cache_req_o},  32'd0);
    check("st c3 wb_valid", {31'd0, dut.wb_valid}, 32'd1);
    cache_data_ack_i = 1'b1;
    step();
    cache_data_ack_i = 1'b0;
    sample();                                     // cycle 4
    check("st c4 wb_valid", {31'd0, dut.wb_valid}, 32'd0);
    check("st c4 req",      {31'd0, cache_req_o},  32'd0);
    step();

    // ---- Store and load to 0x3010 in the same cycle: write first ----
    cpu_wr_req_i  = 1'b1;
    cpu_wr_addr_i = 32'h0000_3010;
    cpu_wr_data_i = 32'h1122_3344;
    cpu_wr_en_i   = 4'h3;
    cpu_rd_req_i  = 1'b1;
    cpu_rd_addr_i = 32'h0000_3010;
    sample();                                     // cycle 0
    check("sl c0 stall", {31'd0, pipeline_stall_o}, 32'd1);
    step();
    cpu_wr_req_i = 1'b0;
    sample();                                     // cycle 1
    check("sl c1 req", {31'd0, cache_req_o}, 32'd0);
    step();
    sample();                                     // cycle 2
    check("sl c2 req",   {31'd0, cache_req_o},   32'd1);
    check("sl c2 op",    {31'd0, cache_op_o},    32'd1);
    check("sl c2 wr_en", {28'd0, cache_wr_en_o}, 32'h3);
    check("sl c2 data",  cache_wr_data_o,        32'h1122_3344);
    cache_addr_ack_i = 1'b1;
    step();
    cache_addr_ack_i = 1'b0;
    sample();                                     // cycle 3
    check("sl c3 req", {31'd0, cache_req_o}, 32'd0);
    cache_data_ack_i = 1'b1;
    step();
    cache_data_ack_i = 1'b0;
    sample();                                     // cycle 4
    check("sl c4 req",   {31'd0, cache_req_o},      32'd0);
    check("sl c4 stall", {31'd0, pipeline_stall_o}, 32'd1);
    step();
    sample();                                     // cycle 5
    check("sl c5 req",    {31'd0, cache_req_o},    32'd1);
    check("sl c5 op",     {31'd0, cache_op_o},     32'd0);
    check("sl c5 wr_en",  {28'd0, cache_wr_en_o},  32'd0);
    check("sl c5 index",  {24'd0, cache_index_o},  32'h01);
    check("sl c5 tag",    {12'd0, cache_tag_o},    32'h00003);
    cache_addr_ack_i = 1'b1;
    step();
    cache_addr_ack_i = 1'b0;
    sample();                                     // cycle 6
    cache_data_ack_i = 1'b1;
    cache_rd_data_i  = 32'hCAFE_F00D;
    step();
    cache_data_ack_i = 1'b0;
    cache_rd_data_i  = 32'h0;
    sample();                                     // cycle 7
    check("sl c7 valid", {31'd0, cpu_rd_valid_o}, 32'd1);
    check("sl c7 data",  cpu_rd_data_o,           32'hCAFE_F00D);
    cpu_rd_req_i = 1'b0;
    step();

    // ---- Second store while full, addr_ack delayed 5 cycles ----
    cpu_wr_req_i  = 1'b1;
    cpu_wr_addr_i = 32'h0000_4000;
    cpu_wr_data_i = 32'hA5A5_A5A5;
    cpu_wr_en_i   = 4'hF;
    step();                                       // cycle 1: store B offered
    cpu_wr_addr_i = 32'h0000_5004;
    cpu_wr_data_i = 32'h0BAD_F00D;
    cpu_wr_en_i   = 4'hC;
    sample();
    check("full c1 stall", {31'd0, pipeline_stall_o}, 32'd1);
    step();
    for (int i = 0; i < 5; i++) begin             // cycles 2..6: no ack
      sample();
      check($sformatf("full wait%0d req", i),   {31'd0, cache_req_o},      32'd1);
      check($sformatf("full wait%0d data", i),  cache_wr_data_o,           32'hA5A5_A5A5);
      check($sformatf("full wait%0d stall", i), {31'd0, pipeline_stall_o}, 32'd1);
      step();
    end
    sample();                                     // cycle 7
    cache_addr_ack_i = 1'b1;
    check("full c7 stall", {31'd0, pipeline_stall_o}, 32'd1);
    step();
    cache_addr_ack_i = 1'b0;
    sample();                                     // cycle 8
    check("full c8 stall", {31'd0, pipeline_stall_o}, 32'd1);
    cache_data_ack_i = 1'b1;
    step();
    cache_data_ack_i = 1'b0;
    sample();                                     // cycle 9: buffer free, B taken
    check("full c9 stall",    {31'd0, pipeline_stall_o}, 32'd0);
    check("full c9 wb_valid", {31'd0, dut.wb_valid},     32'd0);
    step();
    cpu_wr_req_i = 1'b0;
    sample();                                     // cycle 10
    check("full c10 wb_valid", {31'd0, dut.wb_valid}, 32'd1);
    step();
    sample();                                     // cycle 11
    check("full c11 req",    {31'd0, cache_req_o},    32'd1);
    check("full c11 data",   cache_wr_data_o,         32'h0BAD_F00D);
    check("full c11 wr_en",  {28'd0, cache_wr_en_o},  32'hC);
    check("full c11 tag",    {12'd0, cache_tag_o},    32'h00005);
    check("full c11 offset", {28'd0, cache_offset_o}, 32'h4);
    cache_addr_ack_i = 1'b1;
    step();
    cache_addr_ack_i = 1'b0;
    sample();                                     // cycle 12
    cache_data_ack_i = 1'b1;
    step();
    cache_data_ack_i = 1'b0;
    for (int i = 0; i < 4; i++) begin             // no third write appears
      sample();
      check($sformatf("full drained%0d req", i), {31'd0, cache_req_o},  32'd0);
      check($sformatf("full drained%0d wbv", i), {31'd0, dut.wb_valid}, 32'd0);
      step();
    end

    // ---- addr_ack and data_ack together in RD_ADDR ----
    cpu_rd_req_i  = 1'b1;
    cpu_rd_addr_i = 32'h0000_7ABC;
    step();
    sample();                                     // cycle 1
    check("both c1 req",    {31'd0, cache_req_o},    32'd1);
    check("both c1 index",  {24'd0, cache_index_o},  32'hAB);
    check("both c1 tag",    {12'd0, cache_tag_o},    32'h00007);
    check("both c1 offset", {28'd0, cache_offset_o}, 32'hC);
    cache_addr_ack_i = 1'b1;
    cache_data_ack_i = 1'b1;
    cache_rd_data_i  = 32'h1357_9BDF;
    step();
    cache_addr_ack_i = 1'b0;
    cache_data_ack_i = 1'b0;
    cache_rd_data_i  = 32'h0;
    sample();                                     // cycle 2
    check("both c2 valid", {31'd0, cpu_rd_valid_o}, 32'd1);
    check("both c2 data",  cpu_rd_data_o,           32'h1357_9BDF);
    check("both c2 req",   {31'd0, cache_req_o},    32'd0);
    cpu_rd_req_i = 1'b0;
    step();
    sample();
    check("both c3 valid", {31'd0, cpu_rd_valid_o}, 32'd0);
    step();

    // ---- Reset asserted while in RD_DATA ----
    cpu_rd_req_i  = 1'b1;
    cpu_rd_addr_i = 32'h0000_6000;
    step();
    sample();                                     // cycle 1
    cache_addr_ack_i = 1'b1;
    step();
    cache_addr_ack_i = 1'b0;
    sample();                                     // cycle 2: RD_DATA
    check("rst pre state", {29'd0, dut.state_q}, {29'd0, S_RD_DATA});
    rst          = 1'b1;
    cpu_rd_req_i = 1'b0;
    #1;
    check_all_zero("rst mid");
    step();
    rst              = 1'b0;
    cache_data_ack_i = 1'b1;
    cache_rd_data_i  = 32'h9999_9999;
    step();
    cache_data_ack_i = 1'b0;
    cache_rd_data_i  = 32'h0;
    sample();
    check("rst late ack valid", {31'd0, cpu_rd_valid_o}, 32'd0);
    check("rst late ack data",  cpu_rd_data_o,           32'd0);
    check("rst late ack req",   {31'd0, cache_req_o},    32'd0);
    check("rst late ack state", {29'd0, dut.state_q},    {29'd0, S_IDLE});
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_core_cache_ctrl
